// File: rtl/multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl
//   Moore control FSM for a multi-cycle MIPS datapath. It sequences
//   FETCH / DECODE / EXECUTE / MEM / WRITEBACK and drives the datapath enables
//   and mux selects from the current state. It also counts retired
//   instructions.
//
//   The only input-dependent outputs are IRWrite and PCWrite in FETCH. Both
//   follow MemReady, so the instruction register and the PC update only on the
//   cycle in which the fetch actually completes.
//
// Optional feature (compile-time macro CTRL_ILLEGAL_TRAP_EN):
//   defined   : an illegal opcode seen in DECODE enters TRAP. TRAP raises
//               Illegal, holds every other control low and stays there until
//               RST. The trapping instruction is not counted as retired.
//   undefined : an illegal opcode is treated as a NOP. The FSM returns to FETCH
//               and counts the instruction as retired. TRAP is unreachable and
//               Illegal is tied low.
//
// Ports
//   CLK, RST        clock (rising edge) and synchronous active-high reset
//   Op, Funct       instruction fields (Funct is decoded by ALU control, not here)
//   Zero            ALU zero flag (qualifies PCWriteCond in the datapath)
//   MemReady        memory completes the current access this cycle
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
//   RegWrite, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0], PCSource[1:0]
//                   datapath controls
//   State           current state encoding (debug)
//   RetCnt          retired-instruction counter, wraps modulo 2^RET_CNT_WIDTH
//   Illegal         illegal-opcode trap flag
// ---------------------------------------------------------------------------
module multi_cycle_ctrl #(
    parameter int RET_CNT_WIDTH = 32,
    parameter int STATE_WIDTH   = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [5:0]               Op,
    input  logic [5:0]               Funct,
    input  logic                     Zero,
    input  logic                     MemReady,
    output logic                     PCWrite,
    output logic                     PCWriteCond,
    output logic                     IorD,
    output logic                     MemRead,
    output logic                     MemWrite,
    output logic                     IRWrite,
    output logic                     RegDst,
    output logic                     MemtoReg,
    output logic                     RegWrite,
    output logic                     ALUSrcA,
    output logic [1:0]               ALUSrcB,
    output logic [1:0]               ALUOp,
    output logic [1:0]               PCSource,
    output logic [STATE_WIDTH-1:0]   State,
    output logic [RET_CNT_WIDTH-1:0] RetCnt,
    output logic                     Illegal
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_TRAP   = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_e                   state_q, state_d;
    logic [RET_CNT_WIDTH-1:0] retcnt_q, retcnt_d;
    logic                     retire;

    // Funct is decoded by the ALU control, and Zero is consumed by the PC
    // write-enable logic. Neither one affects sequencing.
    logic unused_inputs;
    assign unused_inputs = ^{Funct, Zero};

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_FETCH;
            retcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            retcnt_q <= retcnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and retirement
    //   An instruction retires on the transition that brings it back to
    //   FETCH. A branch retires whether or not it is taken.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (Op)
                    OP_RTYPE:      state_d = S_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_ADDI:       state_d = S_ADDIEX;
                    default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        state_d = S_TRAP;
`else
                        // Unknown opcode behaves as a NOP and still retires.
                        state_d = S_FETCH;
                        retire  = 1'b1;
`endif
                    end
                endcase
            end
            S_MEMADR: state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (MemReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEMWR: begin
                if (MemReady) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC:   state_d = S_RWB;
            S_RWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_BRANCH: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP:   state_d = S_TRAP;   // only RST leaves TRAP
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    // The counter simply wraps modulo 2^RET_CNT_WIDTH.
    assign retcnt_d = retire ? retcnt_q + 1'b1 : retcnt_q;

    // ------------------------------------------------------------------
    // Control outputs, decoded from state (Moore). MemRead and MemWrite
    // depend only on state, so they stay steady across stall cycles.
    // ------------------------------------------------------------------
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'd0;
        ALUOp       = 2'd0;
        PCSource    = 2'd0;
        unique case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'd1;
                IRWrite = MemReady;   // capture instruction and PC+4 together
                PCWrite = MemReady;
            end
            S_DECODE: ALUSrcB = 2'd3;   // precompute branch target
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'd2;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'd1;
                PCWriteCond = 1'b1;
                PCSource    = 2'd1;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'd2;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
            end
            S_ADDIWB: RegWrite = 1'b1;
            default: ;
        endcase
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign Illegal = (state_q == S_TRAP);
`else
    assign Illegal = 1'b0;
`endif

    assign State  = STATE_WIDTH'(state_q);
    assign RetCnt = retcnt_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl. Each instruction is modelled as the
// list of states it visits, and the memory states repeat while MemReady is
// low. The stimulus pushes the expected per-cycle response, and a negedge
// monitor pops each entry and compares it with the DUT.
module tb_multi_cycle_ctrl;
    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         RST, Zero, MemReady;
    logic [5:0]   Op, Funct;
    logic         PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic         RegDst, MemtoReg, RegWrite, ALUSrcA, Illegal;
    logic [1:0]   ALUSrcB, ALUOp, PCSource;
    logic [3:0]   State;
    logic [W-1:0] RetCnt;

    multi_cycle_ctrl #(.RET_CNT_WIDTH(W), .STATE_WIDTH(4)) dut (
        .CLK(CLK), .RST(RST), .Op(Op), .Funct(Funct), .Zero(Zero),
        .MemReady(MemReady), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .State(State), .RetCnt(RetCnt), .Illegal(Illegal)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, srca;
        logic [1:0] srcb, aluop, pcsrc;
        logic ill;
    } ctl_t;

    typedef struct packed {
        logic [3:0]   st;
        logic [W-1:0] cnt;
        ctl_t         c;
    } exp_t;

    exp_t q[$];
    exp_t e;
    ctl_t act;
    int   n_chk = 0, n_pass = 0;
    int   m_cnt = 0;   // reference retired count

    // Control outputs expected in each named state.
    function automatic ctl_t ctl(input int st, input logic mr);
        ctl_t c = '0;
        case (st)
            0:  begin c.mrd = 1; c.srcb = 1; c.irw = mr; c.pcw = mr; end
            1:  c.srcb = 3;
            2:  begin c.srca = 1; c.srcb = 2; end
            3:  begin c.mrd = 1; c.iord = 1; end
            4:  begin c.rw = 1; c.m2r = 1; end
            5:  begin c.mwr = 1; c.iord = 1; end
            6:  begin c.srca = 1; c.aluop = 2; end
            7:  begin c.rw = 1; c.rdst = 1; end
            8:  begin c.srca = 1; c.aluop = 1; c.pcwc = 1; c.pcsrc = 1; end
            9:  begin c.pcw = 1; c.pcsrc = 2; end
            10: begin c.srca = 1; c.srcb = 2; end
            11: c.rw = 1;
            12: c.ill = 1;
            default: ;
        endcase
        return c;
    endfunction

    // Drive one cycle: set inputs, record the expected response, then advance.
    task automatic cyc(input logic [5:0] op, input logic mr, input logic rst,
                       input int st);
        exp_t x;
        Op = op; MemReady = mr; RST = rst;
        Funct = 6'($urandom); Zero = 1'($urandom);
        x.st = 4'(st); x.cnt = W'(m_cnt); x.c = ctl(st, mr);
        q.push_back(x);
        @(posedge CLK); #1;
        if (rst) m_cnt = 0;
    endtask

    // Run one whole instruction. rd_stall < 0 draws random MemReady values;
    // otherwise MemReady is high except for the first rd_stall MEMRD cycles.
    task automatic run_instr(input logic [5:0] op, input int rd_stall);
        int  path[$];
        bit  retires = 1;
        bit  trap = 0;
        int  st, nrd;
        logic mr;
        case (op)
            6'h00: path = '{0, 1, 6, 7};
            6'h23: path = '{0, 1, 2, 3, 4};
            6'h2B: path = '{0, 1, 2, 5};
            6'h04: path = '{0, 1, 8};
            6'h02: path = '{0, 1, 9};
            6'h08: path = '{0, 1, 10, 11};
            default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                path = '{0, 1, 12}; retires = 0; trap = 1;
`else
                path = '{0, 1};
`endif
            end
        endcase
        nrd = 0;
        foreach (path[k]) begin
            st = path[k];
            if (trap && st == 12) begin
                // TRAP holds until reset, and RST always wins.
                repeat (3) cyc(op, 1'($urandom), 1'b0, 12);
                cyc(op, 1'b1, 1'b1, 12);
            end else begin
                do begin
                    if (rd_stall < 0)
                        mr = ($urandom_range(99) >= 30);
                    else begin
                        mr = !(st == 3 && nrd < rd_stall);
                        if (st == 3) nrd++;
                    end
                    cyc(op, mr, 1'b0, st);
                end while ((st == 0 || st == 3 || st == 5) && !mr);
            end
        end
        if (retires) m_cnt = (m_cnt + 1) % (1 << W);
    endtask

    // Monitor: compares whenever an expected entry is pending.
    always @(negedge CLK) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            act = '{PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                    RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                    PCSource, Illegal};
            n_chk++;
            if (State === e.st) n_pass++;
            else $display("FAIL state: got %0d expected %0d", State, e.st);
            n_chk++;
            if (RetCnt === e.cnt) n_pass++;
            else $display("FAIL retcnt: got %0d expected %0d (state %0d)", RetCnt, e.cnt, e.st);
            n_chk++;
            if (act === e.c) n_pass++;
            else $display("FAIL ctrl: got %b expected %b (state %0d)", act, e.c, e.st);
        end
    end

    logic [5:0] ops[8];

    initial begin
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F, 6'h15};
        RST = 1; MemReady = 0; Op = 0; Funct = 0; Zero = 0;
        @(posedge CLK); #1;                  // state unknown before the first edge
        cyc(6'h00, 1'b0, 1'b1, 0);           // second reset cycle: FETCH, count 0
        cyc(6'h00, 1'b0, 1'b0, 0);           // fetch stall with IRWrite low

        run_instr(6'h00, 0);                 // add
        run_instr(6'h23, 3);                 // lw held 4 cycles in MEMRD
        run_instr(6'h04, 0);                 // beq (Zero random)
        run_instr(6'h04, 0);
        run_instr(6'h2B, 0);                 // sw
        run_instr(6'h08, 0);                 // addi

        // Reset while MEMRD is stalled: the next cycle is FETCH with count 0.
        cyc(6'h23, 1'b1, 1'b0, 0);
        cyc(6'h23, 1'b0, 1'b0, 1);
        cyc(6'h23, 1'b0, 1'b0, 2);
        cyc(6'h23, 1'b0, 1'b0, 3);
        cyc(6'h23, 1'b0, 1'b1, 3);

        // 17 jumps from a count of 0 wrap the counter past all-ones.
        repeat (17) run_instr(6'h02, 0);

        run_instr(6'h3F, 0);                 // illegal opcode

        repeat (80) run_instr(ops[$urandom_range(7)], -1);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
        if (q.size() > 0) begin
            n_chk++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
